// File: rtl/sumlink_rx_pkg.sv
// Shared constants and word classification for the partial-sum link receiver.
package sumlink_rx_pkg;

  localparam logic [15:0] CH_COMMA = 16'h00BC;

  localparam logic [1:0] ST_LOST   = 2'b00;
  localparam logic [1:0] ST_HUNT   = 2'b01;
  localparam logic [1:0] ST_LOCKED = 2'b10;

  typedef enum logic [1:0] {
    WC_COMMA = 2'd0,
    WC_DATA  = 2'd1,
    WC_ERR   = 2'd2
  } word_class_e;

  // Any K-character other than K28.5 is treated as a coding error.
  function automatic word_class_e classify(input logic [15:0] d, input logic k, input logic e);
    if (e) return WC_ERR;
    if (k) return (d == CH_COMMA) ? WC_COMMA : WC_ERR;
    return WC_DATA;
  endfunction

endpackage

// File: rtl/sumlink_dly.sv
// Variable-tap delay line for {valid, data} with output blanking after a tap change.
module sumlink_dly
  import sumlink_rx_pkg::*;
#(
  parameter int DMAX = 16,
  parameter int DW   = $clog2(DMAX)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] delay,
  input  logic          in_valid,
  input  logic [15:0]   in_data,
  output logic          out_valid,
  output logic [15:0]   out_data
);

  localparam int            BW        = $clog2(DMAX + 2);
  localparam logic [BW-1:0] BLANK_LEN = BW'(DMAX + 1);
  localparam logic [DW-1:0] ONE       = DW'(1);

  logic [16:0]   line_q [DMAX-1];
  logic [16:0]   line_d [DMAX-1];
  logic [DW-1:0] delay_q;
  logic [BW-1:0] blank_q, blank_d;
  logic          out_valid_q, out_valid_d;
  logic [15:0]   out_data_q, out_data_d;
  logic [16:0]   tap;
  logic [DW-1:0] tap_idx;
  logic          changed;

  always_comb begin
    line_d[0] = {in_valid, in_data};
    for (int i = 1; i < DMAX - 1; i++) line_d[i] = line_q[i-1];
  end

  // Tap 0 bypasses the line so the output register alone sets the minimum latency.
  always_comb begin
    tap_idx = delay - ONE;
    tap     = (delay == '0) ? {in_valid, in_data} : line_q[tap_idx];
    changed = (delay != delay_q);
    if (changed)              blank_d = BLANK_LEN;
    else if (blank_q != '0)   blank_d = blank_q - BW'(1);
    else                      blank_d = blank_q;
    out_valid_d = tap[16] && !changed && (blank_q == '0);
    out_data_d  = out_valid_d ? tap[15:0] : 16'h0000;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DMAX - 1; i++) line_q[i] <= '0;
      delay_q     <= '0;
      blank_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= 16'h0000;
    end else begin
      for (int i = 0; i < DMAX - 1; i++) line_q[i] <= line_d[i];
      delay_q     <= delay;
      blank_q     <= blank_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule

// File: rtl/sumlink_rx.sv
// Partial-sum link receiver: word classification, lock FSM, error counter, alignment delay.
module sumlink_rx
  import sumlink_rx_pkg::*;
#(
  parameter int DMAX  = 16,
  parameter int NLOCK = 4,
  parameter int TMO   = 1024,
  parameter int DW    = $clog2(DMAX)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [15:0]   rxdata,
  input  logic          rxisk,
  input  logic          rxerr,
  input  logic [DW-1:0] delay,
  input  logic          errclr,
  output logic [15:0]   sumout,
  output logic          sumvalid,
  output logic          locked,
  output logic [1:0]    state,
  output logic [15:0]   errcnt
);

  localparam int            CW       = $clog2(NLOCK + 1);
  localparam int            TW       = $clog2(TMO);
  localparam logic [CW-1:0] NLOCK_C  = CW'(NLOCK);
  localparam logic [TW-1:0] TMO_LAST = TW'(TMO - 1);

  logic [15:0]   rxdata_q;
  logic          rxisk_q, rxerr_q;
  logic [1:0]    state_q, state_d;
  logic [CW-1:0] comma_q, comma_d, comma_inc;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [15:0]   errcnt_q, errcnt_d;
  word_class_e   wc;
  logic          is_err, word_valid;

  always_comb begin
    wc         = classify(rxdata_q, rxisk_q, rxerr_q);
    is_err     = (wc == WC_ERR);
    word_valid = (wc == WC_DATA) && (state_q == ST_LOCKED);
    comma_inc  = comma_q + CW'(1);
  end

  always_comb begin
    state_d = state_q;
    comma_d = comma_q;
    tmo_d   = tmo_q;
    case (state_q)
      ST_LOST: begin
        if (wc == WC_COMMA) begin
          state_d = ST_HUNT;
          comma_d = CW'(1);
          tmo_d   = '0;
        end
      end
      ST_HUNT, ST_LOCKED: begin
        if (wc == WC_COMMA) begin
          tmo_d = '0;
          if (state_q == ST_HUNT) begin
            comma_d = comma_inc;
            if (comma_inc == NLOCK_C) state_d = ST_LOCKED;
          end
        end else if (is_err || (tmo_q == TMO_LAST)) begin
          state_d = ST_LOST;
          comma_d = '0;
          tmo_d   = '0;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      default: begin
        state_d = ST_LOST;
        comma_d = '0;
        tmo_d   = '0;
      end
    endcase
  end

  // A same-cycle error survives errclr so no bad word goes uncounted.
  always_comb begin
    errcnt_d = errcnt_q;
    if (errclr)                              errcnt_d = is_err ? 16'd1 : 16'd0;
    else if (is_err && errcnt_q != 16'hFFFF) errcnt_d = errcnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxdata_q <= 16'h0000;
      rxisk_q  <= 1'b0;
      rxerr_q  <= 1'b0;
      state_q  <= ST_LOST;
      comma_q  <= '0;
      tmo_q    <= '0;
      errcnt_q <= 16'h0000;
    end else begin
      rxdata_q <= rxdata;
      rxisk_q  <= rxisk;
      rxerr_q  <= rxerr;
      state_q  <= state_d;
      comma_q  <= comma_d;
      tmo_q    <= tmo_d;
      errcnt_q <= errcnt_d;
    end
  end

  sumlink_dly #(.DMAX(DMAX), .DW(DW)) u_dly (
    .clk      (clk),
    .rst_n    (rst_n),
    .delay    (delay),
    .in_valid (word_valid),
    .in_data  (rxdata_q),
    .out_valid(sumvalid),
    .out_data (sumout)
  );

  assign locked = (state_q == ST_LOCKED);
  assign state  = state_q;
  assign errcnt = errcnt_q;

endmodule

// File: doc/sumlink_rx.md
Name: sumlink_rx

Overview:
- Receive end of the inter-FPGA partial-sum link.
- Takes one transceiver word stream carrying 16-channel sums or K28.5 commas, and qualifies link lock.
- Rejects coding errors and applies a programmable alignment delay so all three remote links reach the master sum adder in the same cycle.
- Outputs a 16-bit sum plus a valid flag; three instances feed the 64-channel trigger logic.

Parameters:
- DMAX, 16: alignment delay line depth; programmable delay range is 0..DMAX-1.
- NLOCK, 4: commas required in HUNT before LOCKED.
- TMO, 1024: cycles without a comma that force LOST.

Ports:
- clk  in  1  master clock
- rst_n  in  1  asynchronous active-low reset
- rxdata  in  16  received word from transceiver
- rxisk  in  1  K-character flag for rxdata
- rxerr  in  1  disparity / not-in-table error from transceiver
- delay  in  log2(DMAX)  alignment delay in cycles
- errclr  in  1  synchronous clear of error counter
- sumout  out  16  remote 16-channel sum, 0 when not valid
- sumvalid  out  1  sumout carries a data word
- locked  out  1  state == LOCKED
- state  out  2  00 LOST, 01 HUNT, 10 LOCKED
- errcnt  out  16  saturating count of bad words

Behaviour:
- Reset values: sumout=0, sumvalid=0, locked=0, state=LOST, errcnt=0, delay line all invalid, timeout and comma counters 0.
- Stage 1 registers rxdata, rxisk and rxerr, then classifies each word:
  - comma: rxisk=1 and rxdata=16'h00BC, rxerr=0.
  - error: rxerr=1, or rxisk=1 with any other value.
  - data: everything else.
- State machine, evaluated once per classified word:
  - LOST: comma -> HUNT with commacnt=1. Data and error words are ignored.
  - HUNT: comma increments commacnt; when commacnt reaches NLOCK -> LOCKED. Error -> LOST.
  - LOCKED: error -> LOST.
  - HUNT or LOCKED: timeout counter clears on every comma and increments otherwise. Reaching TMO-1 on a non-comma word -> LOST.
  - Error and timeout on the same word -> LOST; one error is counted.
- Qualification: a word is valid iff it is a data word and the state before that word's update is LOCKED. The first data word after the NLOCK-th comma is therefore valid. The error word that drops lock is invalid.
- Delay line: {valid, data} pairs enter a shift structure, and the tap is selected by delay.
  - delay=0 bypasses the line.
  - Output register follows the tap.
  - Total latency rxdata -> sumout is 2+delay cycles.
- Delay change: any change of delay forces sumvalid=0 and sumout=0 for the next DMAX+2 cycles (blanking counter). This covers stale line contents. Normal output resumes afterwards.
- Invalid outputs drive sumout=0, so the downstream adder needs no masking.
- errcnt:
  - +1 per error word in any state; saturates at 16'hFFFF.
  - errclr has priority over increment but not over a same-cycle error: errclr and error together -> errcnt=1.
- Reset mid-stream: all state returns to reset values immediately (asynchronous); the delay line is invalidated. Deassertion is synchronised by the instantiating top level.
- locked and state are registered and update one cycle after the classified word.

Decomposition:
- Shared package holds:
  - CH_COMMA = 16'h00BC.
  - State encodings LOST/HUNT/LOCKED.
  - Word class encoding (COMMA/DATA/ERR).
- One natural sub-module, sumlink_dly: parameterised DMAX x 17-bit variable-tap delay with valid bit and flush-on-change blanking.
- Classification, FSM and counters stay in the top.

Test Plan:
- Lock-up:
  - delay=0; after reset send 4 commas then data 16'h0123.
  - Required: state LOST->HUNT->LOCKED; sumout=0x0123 with sumvalid=1 exactly 2 cycles after the data word.
- Error drop:
  - While LOCKED, inject rxerr=1 with data 0x0456.
  - Required: sumvalid stays 0 for that word, state=LOST, errcnt increments 0->1.
  - Subsequent data words are invalid until 4 new commas arrive.
- Timeout:
  - While LOCKED, send 1024 consecutive data words with no comma.
  - Required: state becomes LOST on the 1024th word; the following words have sumvalid=0.
- Alignment:
  - delay=5, locked; send data 0x0010, 0x0020.
  - Required: they appear on sumout 7 and 8 cycles after input.
  - Change delay to 2: sumvalid=0 for 18 cycles, then data appears at latency 4.
- Bad K-code and saturation:
  - rxisk=1 with rxdata=0x00FC -> counted as error and drops HUNT to LOST.
  - Preload errcnt to 0xFFFF by forcing errors -> stays 0xFFFF.
  - errclr together with an error -> errcnt=1.
- Async reset mid-stream:
  - Assert rst_n=0 during LOCKED traffic with delay=3.
  - Required: all outputs 0 and state=LOST immediately.
  - After release, no stale data emerges from the delay line.
